npu_output_handling: RTL and testbench
======================================

Name: npu_output_handling

Overview:
- Drains 32-bit result words from the NPU output FIFO.
- Packs each pair of words into one 64-bit word and stores it in an internal result RAM.
- Exposes the RAM to a downstream consumer through a 16-bit read address, with an `output_ready` flag that marks valid entries.
- Sits between the `npu` output FIFO port and the system-side result reader.

Parameters:
- ADDR_W, 10, log2 of result-RAM depth in 64-bit words (DEPTH = 2^ADDR_W); legal range 1..16.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- output_fifo_empty  input  1  NPU output FIFO empty flag.
- output_data  input  32  NPU output FIFO read data; valid one cycle after a read-enable cycle.
- ram_address  input  16  consumer read address, in 64-bit words.
- output_fifo_read_enable  output  1  pop request to the NPU output FIFO.
- ram_data  output  64  result-RAM contents at ram_address.
- output_ready  output  1  high when ram_address points at a written entry.

Behaviour:
- Reset (reset=0, asynchronous):
  - Clears the write pointer, the written-word count (ADDR_W+1 bits), the in-flight flag, the low-half holding register and the half-select bit.
  - Forces output_fifo_read_enable=0 and output_ready=0.
  - RAM contents are not cleared; ram_data is don't-care while output_ready=0.
  - Reset mid-operation discards any held low half and any in-flight read.
- Read request, combinational: output_fifo_read_enable = reset & ~output_fifo_empty & ~stop.
  - stop is high when 32-bit words written plus words held plus words in flight ≥ 2·DEPTH, i.e. RAM space is exhausted.
  - At most one pop per cycle; a pop may be issued every cycle.
- FIFO read latency is 1 cycle: output_data sampled at edge N+1 belongs to the pop issued in cycle N.
  - A registered in-flight flag tracks the pop.
- Packing:
  - First word of a pair → low half [31:0], held in a register; half-select toggles.
  - Second word → forms {second, held_low} as [63:32]/[31:0].
  - The 64-bit word is written to mem[wr_ptr] on the same edge; wr_ptr and count both increment.
  - wr_ptr wraps is unreachable: writes stop at count = DEPTH (full). No further pops; RAM holds until reset.
- An odd trailing word stays held (invisible) until its partner arrives.
- Read side is combinational (asynchronous read):
  - ram_data = mem[ram_address[ADDR_W-1:0]].
  - output_ready = (ram_address < count) using the full 16-bit address, so addresses ≥ DEPTH are never ready.
- A consumer that increments ram_address on every clock edge where output_ready=1 receives each word exactly once, in write order.
- Simultaneous write to entry k and read of address k:
  - output_ready for k rises the cycle after the write edge.
  - ram_data then shows the new value.
  - No read-during-write hazard is visible.
- Empty FIFO: no pops, no state change.
- An empty flag deasserting for one cycle yields exactly one pop.

Test Plan:
- Reset: hold reset=0 for 6 cycles while output_fifo_empty=0 → output_fifo_read_enable=0, output_ready=0. Release → read_enable=1 in the first cycle after release.
- Basic pack: FIFO supplies 0x11111111 then 0x22222222, consumer at address 0 → after 2nd data edge, output_ready=1 and ram_data=0x22222222_11111111. Address increments to 1 → output_ready=0.
- Stream with random empty gaps: 2·DEPTH words 0,1,2,… → entry k = {2k+1, 2k}. Consumer reads all DEPTH entries in order, output_ready deasserts at address DEPTH, no pops beyond 2·DEPTH.
- Odd count: 5 words pushed → count=2, output_ready only for addresses 0–1. 6th word → address 2 becomes ready with {w5,w4}.
- Full stop: ADDR_W=2, FIFO never empty → exactly 8 pops, then read_enable stays 0. Address 4 → output_ready=0.
- Mid-stream reset: assert reset while a low half is held and a pop is in flight → after release, count=0, output_ready=0. Next two words pack into entry 0 with no stale data.

Source files
------------

// File: rtl/npu_output_handling.sv
// Drains 32-bit NPU result words, packs pairs into 64-bit entries of an internal
// result RAM, and exposes that RAM to a consumer through an asynchronous read port.
module npu_output_handling #(
  parameter int ADDR_W = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        output_fifo_empty,
  input  logic [31:0] output_data,
  input  logic [15:0] ram_address,
  output logic        output_fifo_read_enable,
  output logic [63:0] ram_data,
  output logic        output_ready
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W+2:0] WORD_LIMIT = (ADDR_W+3)'(2 * DEPTH);

  logic [63:0]       mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W:0]   count;
  logic              in_flight;
  logic              half_sel;
  logic [31:0]       low_hold;

  logic [ADDR_W+2:0] words_used;
  logic              stop;
  logic              wr_en;
  logic [16:0]       count_ext;

  // Every 32-bit word already committed to the RAM, held, or still in flight
  // counts against capacity, so the last pop is never issued without room for it.
  assign words_used = {1'b0, count, 1'b0} + (ADDR_W+3)'(half_sel) + (ADDR_W+3)'(in_flight);
  assign stop       = (words_used >= WORD_LIMIT);

  assign output_fifo_read_enable = reset & ~output_fifo_empty & ~stop;
  assign wr_en                   = in_flight & half_sel;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      count     <= '0;
      in_flight <= 1'b0;
      half_sel  <= 1'b0;
      low_hold  <= '0;
    end else begin
      in_flight <= output_fifo_read_enable;
      if (in_flight) begin
        if (half_sel) begin
          wr_ptr   <= wr_ptr + 1'b1;
          count    <= count + 1'b1;
          half_sel <= 1'b0;
        end else begin
          low_hold <= output_data;
          half_sel <= 1'b1;
        end
      end
    end
  end

  // NOTE: the RAM array is deliberately left out of the reset; entries are only
  // observable once count covers them, so clearing them would buy nothing.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= {output_data, low_hold};
    end
  end

  // Full 16-bit compare: addresses at or beyond DEPTH never alias onto valid entries.
  assign count_ext    = 17'(count);
  assign output_ready = ({1'b0, ram_address} < count_ext);
  assign ram_data     = mem[ram_address[ADDR_W-1:0]];

endmodule

// File: tb/tb_npu_output_handling.sv
// Scoreboard bench for npu_output_handling: a FIFO model feeds words, expected
// 64-bit entries are queued at stimulus time, and a consumer monitor compares them.
module tb_npu_output_handling;

  localparam int ADDR_W = 2;
  localparam int DEPTH  = 1 << ADDR_W;

  logic        clk = 1'b0;
  logic        reset;
  logic        output_fifo_empty;
  logic [31:0] output_data;
  logic [15:0] ram_address;
  logic        output_fifo_read_enable;
  logic [63:0] ram_data;
  logic        output_ready;

  int compared   = 0;
  int mismatched = 0;

  logic [31:0] fifo_q [$];
  logic [63:0] exp_q  [$];
  int          pops      = 0;
  bit          gap_en    = 1'b0;
  bit          mon_en    = 1'b0;
  logic [15:0] mon_addr  = '0;
  logic [15:0] probe_addr = '0;

  assign ram_address = mon_en ? mon_addr : probe_addr;

  always #5 clk = ~clk;

  npu_output_handling #(.ADDR_W(ADDR_W)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .output_fifo_empty       (output_fifo_empty),
    .output_data             (output_data),
    .ram_address             (ram_address),
    .output_fifo_read_enable (output_fifo_read_enable),
    .ram_data                (ram_data),
    .output_ready            (output_ready)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    compared++;
    mismatched++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  task automatic step_sample();
    @(negedge clk);
    #2;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    #2;
    check({name, "_drained"}, 64'(exp_q.size()), 64'd0);
  endtask

  // FIFO model: empty flag set at negedge, pop sampled just before the rising
  // edge, popped word presented just after it (one-cycle read latency).
  initial begin
    output_fifo_empty = 1'b1;
    output_data       = '0;
    forever begin
      logic pe;
      @(negedge clk);
      output_fifo_empty = (fifo_q.size() == 0) || (gap_en && $urandom_range(0, 2) == 0);
      #4;
      pe = output_fifo_read_enable;
      @(posedge clk);
      #1;
      if (pe) begin
        if (fifo_q.size() != 0) output_data = fifo_q.pop_front();
        else fail_now("pop_from_empty_fifo");
        pops++;
      end
    end
  end

  // Consumer monitor: advances the address on every sample where output_ready=1.
  initial begin
    forever begin
      @(negedge clk);
      if (reset !== 1'b1) begin
        mon_addr = '0;
      end else if (mon_en && output_ready) begin
        if (exp_q.size() == 0) fail_now($sformatf("unexpected_entry_%0d", mon_addr));
        else check($sformatf("entry_%0d", mon_addr), ram_data, exp_q.pop_front());
        mon_addr++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    int n;
    reset      = 1'b0;
    probe_addr = '0;

    // Reset hold with a non-empty FIFO
    fifo_q.push_back(32'h11111111);
    fifo_q.push_back(32'h22222222);
    repeat (6) begin
      step_sample();
      check("rst_read_enable", output_fifo_read_enable, 0);
      check("rst_output_ready", output_ready, 0);
    end
    @(negedge clk);
    reset = 1'b1;
    #2;
    check("release_read_enable", output_fifo_read_enable, 1);

    // Basic pack: entry 0 becomes ready after the second data edge
    step_sample();
    check("pack_ready_early1", output_ready, 0);
    step_sample();
    check("pack_ready_early2", output_ready, 0);
    step_sample();
    check("pack_ready", output_ready, 1);
    check("pack_data", ram_data, 64'h22222222_11111111);
    check("pack_pops", 64'(pops), 64'd2);
    probe_addr = 16'd1;
    #1;
    check("pack_addr1_not_ready", output_ready, 0);

    // Odd count: five words leave one held, the sixth completes entry 3
    exp_q.push_back(64'h22222222_11111111);
    for (int i = 0; i < 5; i++) fifo_q.push_back(32'hA0000000 + 32'(i));
    exp_q.push_back(64'hA0000001_A0000000);
    exp_q.push_back(64'hA0000003_A0000002);
    mon_en = 1'b1;
    wait_drain("odd5", 40);
    repeat (4) step_sample();
    check("odd5_consumer_addr", 64'(mon_addr), 64'd3);
    check("odd5_addr3_not_ready", output_ready, 0);
    fifo_q.push_back(32'hA0000005);
    exp_q.push_back(64'hA0000005_A0000004);
    wait_drain("odd6", 20);
    repeat (2) step_sample();
    check("odd6_consumer_addr", 64'(mon_addr), 64'd4);
    check("full_addr4_not_ready", output_ready, 0);

    // RAM full: further FIFO words are never popped
    fifo_q.push_back(32'hBBBBBBBB);
    base = pops;
    repeat (5) step_sample();
    check("full_fifo_not_empty", output_fifo_empty, 0);
    check("full_read_enable", output_fifo_read_enable, 0);
    check("full_no_pops", 64'(pops - base), 64'd0);

    // Full stop from reset with a never-empty FIFO
    @(negedge clk);
    reset = 1'b0;
    fifo_q.delete();
    repeat (2) step_sample();
    check("fs_rst_ready", output_ready, 0);
    for (int i = 0; i < 10; i++) fifo_q.push_back(32'hC0000000 + 32'(i));
    for (int k = 0; k < DEPTH; k++)
      exp_q.push_back({32'hC0000000 + 32'(2*k+1), 32'hC0000000 + 32'(2*k)});
    step_sample();
    base = pops;
    @(negedge clk);
    reset = 1'b1;
    wait_drain("fullstop", 40);
    repeat (5) step_sample();
    check("fullstop_pops", 64'(pops - base), 64'd8);
    check("fullstop_read_enable", output_fifo_read_enable, 0);
    check("fullstop_fifo_not_empty", output_fifo_empty, 0);
    check("fullstop_consumer_addr", 64'(mon_addr), 64'd4);
    check("fullstop_addr4_not_ready", output_ready, 0);

    // Stream with random empty gaps: entry k = {2k+1, 2k}
    @(negedge clk);
    reset = 1'b0;
    fifo_q.delete();
    step_sample();
    for (int i = 0; i < 2*DEPTH + 2; i++) fifo_q.push_back(32'(i));
    for (int k = 0; k < DEPTH; k++) exp_q.push_back({32'(2*k+1), 32'(2*k)});
    gap_en = 1'b1;
    base = pops;
    @(negedge clk);
    reset = 1'b1;
    wait_drain("gap_stream", 200);
    repeat (8) step_sample();
    gap_en = 1'b0;
    repeat (3) step_sample();
    check("gap_pops", 64'(pops - base), 64'(2*DEPTH));
    check("gap_consumer_addr", 64'(mon_addr), 64'(DEPTH));
    check("gap_addr_depth_not_ready", output_ready, 0);

    // Mid-stream reset with a held low half and a pop in flight
    @(negedge clk);
    reset = 1'b0;
    fifo_q.delete();
    step_sample();
    fifo_q.push_back(32'h55550000);
    fifo_q.push_back(32'h55550001);
    base = pops;
    @(negedge clk);
    reset = 1'b1;
    n = 0;
    while (pops < base + 2 && n < 20) begin
      @(posedge clk);
      #2;
      n++;
    end
    check("midrst_two_pops", 64'(pops - base), 64'd2);
    reset = 1'b0;
    #1;
    check("midrst_ready", output_ready, 0);
    step_sample();
    check("midrst_read_enable", output_fifo_read_enable, 0);
    check("midrst_ready_hold", output_ready, 0);
    fifo_q.push_back(32'h77770000);
    fifo_q.push_back(32'h77770001);
    exp_q.push_back(64'h77770001_77770000);
    @(negedge clk);
    reset = 1'b1;
    wait_drain("post_reset", 20);
    repeat (3) step_sample();
    check("post_reset_consumer_addr", 64'(mon_addr), 64'd1);
    check("post_reset_addr1_not_ready", output_ready, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
